// File: rtl/prog_uart_loader_if.sv
// Program-load port: UART serial input plus the word/line write port into dmem/imem.
interface prog_uart_loader_if #(
  parameter int ADDR_LEN = 32
);
  logic                rxd;
  logic [ADDR_LEN-1:0] load_addr;
  logic [127:0]        load_data;
  logic                we_32;
  logic                we_128;
  logic                done;
  logic                frame_err;
  logic                busy;

  modport master (
    input  rxd,
    output load_addr, load_data, we_32, we_128, done, frame_err, busy
  );

  modport slave (
    output rxd,
    input  load_addr, load_data, we_32, we_128, done, frame_err, busy
  );
endinterface

// File: rtl/prog_uart_loader.sv
// UART 8N1 program loader: length header then image, written as 32-bit words and 128-bit lines.
// Write strobes follow the completing byte by one cycle; no backpressure, the serial stream cannot be stalled.
module prog_uart_loader #(
  parameter int                  CLKS_PER_BIT = 868,
  parameter int                  ADDR_LEN     = 32,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR    = '0
) (
  input  logic               clk,
  input  logic               reset_x,
  prog_uart_loader_if.master ld
);

  localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_HDR, LD_LOAD, LD_DONE} ld_state_t;

  rx_state_t   rx_state;
  logic        rxd_s1, rxd_s2, rxd_prev;
  logic [CW-1:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_shift;
  logic        stop_wait;
  logic        byte_vld;

  ld_state_t   ld_state;
  logic [1:0]  hdr_cnt;
  logic [31:0] len_sh;
  logic [31:0] img_len;
  logic [31:0] byte_cnt;
  logic [31:0] word_sh;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      rxd_s1       <= 1'b1;
      rxd_s2       <= 1'b1;
      rxd_prev     <= 1'b1;
      rx_state     <= RX_IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      rx_shift     <= '0;
      stop_wait    <= 1'b0;
      byte_vld     <= 1'b0;
      ld.frame_err <= 1'b0;
    end else begin
      rxd_s1   <= ld.rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      byte_vld <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s2) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_M1) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt  <= '0;
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              rx_state  <= RX_STOP;
              stop_wait <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // After a bad stop bit, hold here until the line returns high so the
          // tail of a long break is not mistaken for a new start bit.
          if (stop_wait) begin
            if (rxd_s2) rx_state <= RX_IDLE;
          end else if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            if (rxd_s2) begin
              byte_vld <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              ld.frame_err <= 1'b1;
              stop_wait    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      ld_state     <= LD_HDR;
      hdr_cnt      <= '0;
      len_sh       <= '0;
      img_len      <= '0;
      byte_cnt     <= '0;
      word_sh      <= '0;
      ld.load_addr <= BASE_ADDR;
      ld.load_data <= '0;
      ld.we_32     <= 1'b0;
      ld.we_128    <= 1'b0;
      ld.done      <= 1'b0;
    end else begin
      ld.we_32  <= 1'b0;
      ld.we_128 <= 1'b0;
      case (ld_state)
        LD_HDR: begin
          if (byte_vld) begin
            len_sh  <= {rx_shift, len_sh[31:8]};
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              img_len  <= {rx_shift, len_sh[31:12], 4'b0000};
              byte_cnt <= '0;
              if ({rx_shift, len_sh[31:12]} == 28'd0) begin
                ld_state <= LD_DONE;
                ld.done  <= 1'b1;
              end else begin
                ld_state <= LD_LOAD;
              end
            end
          end
        end
        LD_LOAD: begin
          if (byte_vld) begin
            word_sh  <= {rx_shift, word_sh[31:8]};
            byte_cnt <= byte_cnt + 32'd1;
            if (byte_cnt[1:0] == 2'd3) begin
              ld.load_data <= {rx_shift, word_sh[31:8], ld.load_data[127:32]};
              // Address of the word's first byte; during we_128 this is the
              // line's last word, whose bits [12:4] still select the line.
              ld.load_addr <= BASE_ADDR + ADDR_LEN'(byte_cnt) - ADDR_LEN'(3);
              ld.we_32     <= 1'b1;
              ld.we_128    <= (byte_cnt[3:2] == 2'd3);
              if (byte_cnt + 32'd1 == img_len) begin
                ld_state <= LD_DONE;
                ld.done  <= 1'b1;
              end
            end
          end
        end
        LD_DONE: ld.done <= 1'b1;
        default: ld_state <= LD_HDR;
      endcase
    end
  end

  assign ld.busy = (ld_state == LD_LOAD) || (ld_state == LD_HDR && hdr_cnt != 2'd0);

endmodule

// File: tb/tb_prog_uart_loader.sv
// Bench for prog_uart_loader: directed header scenarios plus randomized images checked against a byte-stream model.
module tb_prog_uart_loader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_x;
  always #5 clk = ~clk;

  prog_uart_loader_if #(.ADDR_LEN(32)) bus ();
  prog_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_LEN(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset_x(reset_x), .ld(bus)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         w32;
    logic         w128;
    logic         done;
  } rec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       bad;
    logic       glitch;
  } tx_t;

  rec_t rec_q[$];
  tx_t  tx_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk)
    if (bus.we_32 || bus.we_128)
      rec_q.push_back(rec_t'({bus.load_addr, bus.load_data, bus.we_32, bus.we_128, bus.done}));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tx_t mk(input logic [7:0] d, input logic bad, input logic gl);
    tx_t t;
    t.d = d; t.bad = bad; t.glitch = gl;
    return t;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic bad);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rxd = ~bad;
    repeat (CPB) @(negedge clk);
    if (bad) begin
      repeat (2) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic glitch();
    bus.rxd = 1'b0;
    @(negedge clk);
    bus.rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_stream();
    foreach (tx_q[i]) begin
      if (tx_q[i].glitch) glitch();
      send_byte(tx_q[i].d, tx_q[i].bad);
      bus.rxd = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, bus.load_addr, 0);
    check({tag, "_data"}, bus.load_data, 0);
    check({tag, "_we32"}, bus.we_32, 0);
    check({tag, "_we128"}, bus.we_128, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ferr"}, bus.frame_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset(input string tag);
    bus.rxd = 1'b1;
    reset_x = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(tag);
    reset_x = 1'b1;
    repeat (2) @(negedge clk);
    rec_q.delete();
  endtask

  // Reference: drop framing-error bytes, read the header, expect one write per
  // complete image word and a line write on every fourth word.
  task automatic check_model(input string tag);
    logic [7:0]   g[$];
    logic [31:0]  w[$];
    logic [31:0]  len_n;
    logic [127:0] line;
    logic         exp_done;
    int           nw;
    foreach (tx_q[i]) if (!tx_q[i].bad) g.push_back(tx_q[i].d);
    len_n = {g[3], g[2], g[1], g[0]} & 32'hFFFF_FFF0;
    if (len_n <= 32'(g.size() - 4)) begin
      exp_done = 1'b1;
      nw = int'(len_n / 4);
    end else begin
      exp_done = 1'b0;
      nw = (g.size() - 4) / 4;
    end
    for (int i = 0; i < nw; i++)
      w.push_back({g[4 + 4*i + 3], g[4 + 4*i + 2], g[4 + 4*i + 1], g[4 + 4*i]});
    check({tag, "_nwrites"}, rec_q.size(), nw);
    for (int i = 0; i < rec_q.size() && i < nw; i++) begin
      line = '0;
      for (int k = 0; k < 4; k++)
        if (i - k >= 0) line[127 - 32*k -: 32] = w[i - k];
      check($sformatf("%s_addr%0d", tag, i), rec_q[i].addr, 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), rec_q[i].data, line);
      check($sformatf("%s_w32_%0d", tag, i), rec_q[i].w32, 1'b1);
      check($sformatf("%s_w128_%0d", tag, i), rec_q[i].w128, (i % 4) == 3);
      check($sformatf("%s_wdone%0d", tag, i), rec_q[i].done, exp_done && (i == nw - 1));
    end
    check({tag, "_done"}, bus.done, exp_done);
    check({tag, "_busy"}, bus.busy, !exp_done);
  endtask

  task automatic build_scn1();
    tx_q.delete();
    tx_q.push_back(mk(8'h20, 0, 0));
    repeat (3) tx_q.push_back(mk(8'h00, 0, 0));
    for (int i = 0; i < 32; i++) tx_q.push_back(mk(8'(i), 0, 0));
  endtask

  task automatic check_scn1(input string tag);
    check_model(tag);
    if (rec_q.size() == 8) begin
      check({tag, "_first_word"}, rec_q[0].data[127:96], 32'h0302_0100);
      check({tag, "_line0_addr"}, rec_q[3].addr, 32'd12);
      check({tag, "_line0_data"}, rec_q[3].data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      check({tag, "_line1_addr"}, rec_q[7].addr, 32'd28);
      check({tag, "_line1_done"}, rec_q[7].done, 1'b1);
    end
  endtask

  task automatic build_random(input bit with_err);
    int n;
    int pos;
    logic [7:0] len;
    tx_q.delete();
    len = 8'($urandom_range(16, 63));
    tx_q.push_back(mk(len, 0, 0));
    repeat (3) tx_q.push_back(mk(8'h00, 0, 0));
    n = int'(len & 8'hF0) + $urandom_range(0, 6);
    for (int i = 0; i < n; i++) tx_q.push_back(mk(8'($urandom), 0, 0));
    if (with_err) begin
      pos = $urandom_range(4, tx_q.size() - 1);
      tx_q.insert(pos, mk(8'hA5, 1, 0));
      pos = $urandom_range(0, tx_q.size() - 1);
      tx_q[pos].glitch = 1'b1;
    end
  endtask

  initial begin
    bus.rxd = 1'b1;
    reset_x = 1'b1;
    #2;
    do_reset("rst0");

    build_scn1();
    send_stream();
    check_scn1("scn1");

    // N=16 from 0x17, with trailing bytes that must not write
    do_reset("rst1");
    tx_q.delete();
    tx_q.push_back(mk(8'h17, 0, 0));
    repeat (3) tx_q.push_back(mk(8'h00, 0, 0));
    for (int i = 0; i < 20; i++) tx_q.push_back(mk(8'($urandom), 0, 0));
    send_stream();
    check_model("n16");

    // all-zero header: done right after the 4th byte, no writes
    do_reset("rst2");
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("zhdr_busy1", bus.busy, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zhdr_done_early", bus.done, 1'b0);
    repeat (3) @(negedge clk);
    check("zhdr_done", bus.done, 1'b1);
    send_byte(8'h40, 0);
    repeat (5) @(negedge clk);
    check("zhdr_nwrites", rec_q.size(), 0);
    check("zhdr_busy0", bus.busy, 1'b0);

    // glitch in idle: nothing received
    do_reset("rst3");
    glitch();
    check("glitch_ferr", bus.frame_err, 1'b0);
    check("glitch_busy", bus.busy, 1'b0);

    // bad stop bit on 0xA5 inside an image, plus a glitch, then clean bytes
    for (int r = 0; r < 3; r++) begin
      do_reset($sformatf("rstr%0d", r));
      build_random(r != 0);
      send_stream();
      check_model($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_ferr", r), bus.frame_err, r != 0);
    end

    // async reset after 2 image bytes, then the full first scenario again
    do_reset("rst4");
    send_byte(8'h20, 0);
    repeat (3) send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (3) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    #2;
    reset_x = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
    repeat (2) @(negedge clk);
    rec_q.delete();
    build_scn1();
    send_stream();
    check_scn1("scn1b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
